// File: rtl/l2_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter_if
// Purpose  : Bundles the I-cache, D-cache and L2 signals of the L2 port
//            arbiter. The slave modport is the arbiter's view; the master
//            modport is the surrounding caches and L2.
// Revision : 1.0 - initial release
// ============================================================================
interface l2_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BE_W   = LINE_W / 8
);
    // I-cache miss path
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    // D-cache miss / writeback path
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_byte_enable;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    // Shared L2 port
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [BE_W-1:0]   l2_byte_enable;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    // Arbiter side
    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata, d_byte_enable,
        output d_rdata, d_resp,
        output l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable,
        input  l2_rdata, l2_resp
    );

    // Caches and L2 side
    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  d_rdata, d_resp,
        input  l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable,
        output l2_rdata, l2_resp
    );
endinterface
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter
// Purpose  : Shares the single L2 port between the I-cache miss path and the
//            D-cache miss/writeback path. One transaction in flight, request
//            latched at grant, round-robin on ties, response routed only to
//            the granted side.
// Revision : 1.0 - initial release
// ============================================================================
module l2_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BE_W   = LINE_W / 8
) (
    input  logic               clk,
    input  logic               rst,
    l2_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    localparam logic c_GRANT_I = 1'b0;
    localparam logic c_GRANT_D = 1'b1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_is_write;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_busy;

    // Grant decision: a lone requester wins, a tie goes to the side that was not served last
    always_comb begin
        w_i_req   = bus.i_read;
        w_d_req   = bus.d_read | bus.d_write;
        w_grant_d = (r_state == ST_IDLE) && w_d_req &&
                    (!w_i_req || (r_last_grant == c_GRANT_I));
        w_grant_i = (r_state == ST_IDLE) && w_i_req &&
                    (!w_d_req || (r_last_grant == c_GRANT_D));
    end

    // Next state and L2/response outputs; responses are gated to the owner of the transaction
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        bus.i_resp   = 1'b0;
        bus.d_resp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_next = ST_SERVE_D;
                end else if (w_grant_i) begin
                    w_state_next = ST_SERVE_I;
                end
            end
            ST_SERVE_I: begin
                w_busy = 1'b1;
                if (bus.l2_resp) begin
                    bus.i_resp   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_SERVE_D: begin
                w_busy = 1'b1;
                if (bus.l2_resp) begin
                    bus.d_resp   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        bus.l2_read  = w_busy & ~r_is_write;
        bus.l2_write = w_busy &  r_is_write;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the winner's transaction at the grant edge so live inputs never reach the L2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_GRANT_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_is_write   <= 1'b0;
        end else if (w_grant_d) begin
            r_last_grant <= c_GRANT_D;
            r_addr       <= bus.d_address;
            r_wdata      <= bus.d_wdata;
            r_be         <= bus.d_byte_enable;
            // A simultaneous read+write is treated as a write
            r_is_write   <= bus.d_write;
        end else if (w_grant_i) begin
            r_last_grant <= c_GRANT_I;
            r_addr       <= bus.i_address;
            r_wdata      <= '0;
            r_be         <= '1;
            r_is_write   <= 1'b0;
        end
    end

    assign bus.l2_address     = r_addr;
    assign bus.l2_wdata       = r_wdata;
    assign bus.l2_byte_enable = r_be;
    // Read data is broadcast; only the resp pulses identify the recipient
    assign bus.i_rdata        = bus.l2_rdata;
    assign bus.d_rdata        = bus.l2_rdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_port_arbiter
// Purpose  : Self-checking bench for l2_port_arbiter: directed scenarios with
//            literal expectations, then randomized traffic checked every
//            cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BE_W   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BE_W(BE_W)) bus ();

    l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BE_W(BE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int illegal_cycles = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model: at most one open transaction, described by
    // its owner and the request captured when it was opened.
    // ------------------------------------------------------------------
    bit                m_valid   = 0;
    bit                m_open    = 0;
    bit                m_owner_d = 0;
    bit                m_prev_d  = 0;
    bit                m_wr      = 0;
    logic [ADDR_W-1:0] m_addr    = '0;
    logic [LINE_W-1:0] m_wdata   = '0;
    logic [BE_W-1:0]   m_be      = '0;
    int                grants_i  = 0;
    int                grants_d  = 0;

    always @(negedge clk) begin : p_model
        bit want_i, want_d, pick_d;
        if (m_valid) begin
            chk("l2_read",    bus.l2_read,        m_open && !m_wr);
            chk("l2_write",   bus.l2_write,       m_open && m_wr);
            chk("l2_address", bus.l2_address,     m_addr);
            chk("l2_wdata",   bus.l2_wdata,       m_wdata);
            chk("l2_be",      bus.l2_byte_enable, m_be);
            chk("i_resp",     bus.i_resp,         m_open && !m_owner_d && bus.l2_resp);
            chk("d_resp",     bus.d_resp,         m_open && m_owner_d && bus.l2_resp);
            chk("i_rdata",    bus.i_rdata,        bus.l2_rdata);
            chk("d_rdata",    bus.d_rdata,        bus.l2_rdata);
        end
        if (rst) begin
            m_valid = 1; m_open = 0; m_prev_d = 0; m_wr = 0;
            m_addr = '0; m_wdata = '0; m_be = '0;
        end else if (m_open) begin
            if (bus.l2_resp) m_open = 0;
        end else begin
            want_i = bus.i_read;
            want_d = bus.d_read || bus.d_write;
            if (want_i || want_d) begin
                pick_d    = want_i && want_d ? !m_prev_d : want_d;
                m_open    = 1;
                m_owner_d = pick_d;
                m_prev_d  = pick_d;
                if (pick_d) begin
                    grants_d++;
                    m_addr = bus.d_address; m_wdata = bus.d_wdata;
                    m_be = bus.d_byte_enable; m_wr = bus.d_write;
                end else begin
                    grants_i++;
                    m_addr = bus.i_address; m_wdata = '0;
                    m_be = '1; m_wr = 0;
                end
            end
        end
    end

    // Protocol monitor for the illegal simultaneous D read+write
    always @(negedge clk) begin
        if (bus.d_read && bus.d_write) begin
            illegal_cycles++;
            $display("[TB] protocol note: d_read and d_write both high at %0t", $time);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        logic [LINE_W-1:0] pat;
        bit s_i_resp, s_d_resp, s_l2_req;
        rst = 1'b1;
        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = '0;
        bus.d_wdata = '0; bus.d_byte_enable = '0;
        bus.l2_rdata = '0; bus.l2_resp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_l2_read",  bus.l2_read, 0);
        chk("rst_l2_write", bus.l2_write, 0);
        chk("rst_i_resp",   bus.i_resp, 0);
        chk("rst_d_resp",   bus.d_resp, 0);
        chk("rst_l2_addr",  bus.l2_address, 0);
        chk("rst_l2_be",    bus.l2_byte_enable, 0);

        // I-cache read, L2 answers three cycles after the request
        tick(); rst = 0; bus.i_read = 1; bus.i_address = 32'h0000_1000;
        @(negedge clk); chk("t1_idle_no_req", bus.l2_read, 0);
        tick();
        @(negedge clk);
        chk("t1_l2_read", bus.l2_read, 1);
        chk("t1_l2_addr", bus.l2_address, 32'h0000_1000);
        chk("t1_l2_be",   bus.l2_byte_enable, 32'hFFFF_FFFF);
        tick(); @(negedge clk); chk("t1_wait_no_resp", bus.i_resp, 0);
        tick(); pat = {8{32'h1234_5678}}; bus.l2_resp = 1; bus.l2_rdata = pat;
        @(negedge clk);
        chk("t1_i_resp", bus.i_resp, 1);
        chk("t1_i_rdata", bus.i_rdata, pat);
        chk("t1_d_resp", bus.d_resp, 0);
        tick(); bus.l2_resp = 0; bus.i_read = 0;
        @(negedge clk); chk("t1_after_resp", bus.l2_read, 0);

        // D-cache write; live inputs become garbage during service
        tick(); bus.d_write = 1; bus.d_address = 32'h0000_2000;
        bus.d_wdata = {32{8'hA5}}; bus.d_byte_enable = 32'hFFFF_0000;
        @(negedge clk);
        tick(); bus.d_address = 32'hDEAD_BEEF; bus.d_wdata = rand_line(); bus.d_byte_enable = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("t2_l2_write", bus.l2_write, 1);
        chk("t2_l2_addr",  bus.l2_address, 32'h0000_2000);
        chk("t2_l2_wdata", bus.l2_wdata, {32{8'hA5}});
        chk("t2_l2_be",    bus.l2_byte_enable, 32'hFFFF_0000);
        tick(); bus.l2_resp = 1;
        @(negedge clk);
        chk("t2_d_resp", bus.d_resp, 1);
        chk("t2_i_resp", bus.i_resp, 0);
        tick(); bus.l2_resp = 0; bus.d_write = 0;

        // Tie right after reset: D first, then strict alternation, one IDLE gap each
        tick(); rst = 1;
        tick(); rst = 0; bus.i_read = 1; bus.d_read = 1;
        bus.i_address = 32'h0000_3000; bus.d_address = 32'h0000_4000;
        @(negedge clk); chk("t3_idle", bus.l2_read, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); @(negedge clk);
            chk("t3_l2_read", bus.l2_read, 1);
            chk("t3_grant_addr", bus.l2_address, (k % 2 == 0) ? 32'h0000_4000 : 32'h0000_3000);
            tick(); bus.l2_resp = 1;
            if (k == 3) begin bus.i_read = 0; bus.d_read = 0; end
            @(negedge clk);
            chk("t3_d_resp", bus.d_resp, (k % 2 == 0));
            chk("t3_i_resp", bus.i_resp, (k % 2 == 1));
            tick(); bus.l2_resp = 0;
            @(negedge clk); chk("t3_gap_idle", bus.l2_read, 0);
        end

        // Reset while D waits for the L2; next tie goes to D again
        tick(); bus.d_read = 1; bus.d_address = 32'h0000_5000;
        @(negedge clk);
        tick(); @(negedge clk); chk("t4_serving", bus.l2_read, 1);
        tick(); rst = 1; bus.d_read = 0;
        @(negedge clk);
        tick(); rst = 0; bus.i_read = 1; bus.d_read = 1;
        bus.i_address = 32'h0000_6100; bus.d_address = 32'h0000_6200;
        @(negedge clk);
        chk("t4_rst_read",  bus.l2_read, 0);
        chk("t4_rst_write", bus.l2_write, 0);
        chk("t4_rst_addr",  bus.l2_address, 0);
        tick(); @(negedge clk); chk("t4_tie_to_d", bus.l2_address, 32'h0000_6200);
        tick(); bus.l2_resp = 1; bus.d_read = 0;
        @(negedge clk); chk("t4_d_resp", bus.d_resp, 1);
        tick(); bus.l2_resp = 0;
        @(negedge clk); chk("t4_gap", bus.l2_read, 0);
        tick(); @(negedge clk); chk("t4_then_i", bus.l2_address, 32'h0000_6100);
        tick(); bus.l2_resp = 1; bus.i_read = 0;
        @(negedge clk); chk("t4_i_resp_dropped_req", bus.i_resp, 1);
        tick(); bus.l2_resp = 0;

        // Spurious L2 response while idle
        tick(); bus.l2_resp = 1;
        @(negedge clk);
        chk("t5_idle_i_resp", bus.i_resp, 0);
        chk("t5_idle_d_resp", bus.d_resp, 0);
        tick(); bus.l2_resp = 0;

        // Illegal read+write: treated as a write
        tick(); bus.d_read = 1; bus.d_write = 1; bus.d_address = 32'h0000_7000;
        @(negedge clk);
        tick(); @(negedge clk);
        chk("t6_is_write", bus.l2_write, 1);
        chk("t6_not_read", bus.l2_read, 0);
        tick(); bus.l2_resp = 1; bus.d_read = 0; bus.d_write = 0;
        @(negedge clk); chk("t6_d_resp", bus.d_resp, 1);
        tick(); bus.l2_resp = 0;
        @(negedge clk); chk("t6_illegal_seen", illegal_cycles, 2);

        // Randomized traffic, checked every cycle by the model
        grants_i = 0; grants_d = 0;
        s_i_resp = 0; s_d_resp = 0; s_l2_req = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (bus.i_read) begin
                if (s_i_resp || $urandom_range(0, 63) == 0) bus.i_read = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.i_read = 1;
            end
            if (bus.d_read || bus.d_write) begin
                if (s_d_resp || $urandom_range(0, 63) == 0) begin
                    bus.d_read = 0; bus.d_write = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) bus.d_write = 1;
                else bus.d_read = 1;
            end
            bus.i_address     = $urandom;
            bus.d_address     = $urandom;
            bus.d_wdata       = rand_line();
            bus.d_byte_enable = $urandom;
            bus.l2_rdata      = rand_line();
            bus.l2_resp       = s_l2_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rst               = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            s_i_resp = bus.i_resp;
            s_d_resp = bus.d_resp;
            s_l2_req = bus.l2_read || bus.l2_write;
        end
        tick();
        rst = 0; bus.i_read = 0; bus.d_read = 0; bus.d_write = 0; bus.l2_resp = 0;
        repeat (2) tick();
        chk("rand_both_sides_granted", (grants_i > 10) && (grants_d > 10), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
